// File: rtl/alu_arbiter.sv
// alu_arbiter: two-requester round-robin front end for a single shared, externally attached ALU.
// Operands are latched on accept, and the result is held until the owning requester takes it.
module alu_arbiter #(
    parameter int REG_WIDTH  = 32,
    parameter int MUL_CYCLES = 3
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [1:0]             req_valid,
    output logic [1:0]             req_ready,
    input  logic [7:0]             req_ctl,
    input  logic [2*REG_WIDTH-1:0] req_a,
    input  logic [2*REG_WIDTH-1:0] req_b,
    output logic [1:0]             rsp_valid,
    input  logic [1:0]             rsp_ready,
    output logic [REG_WIDTH-1:0]   rsp_data,
    output logic                   rsp_lt,
    output logic [3:0]             alu_ctl,
    output logic [REG_WIDTH-1:0]   alu_a,
    output logic [REG_WIDTH-1:0]   alu_b,
    input  logic [REG_WIDTH-1:0]   alu_out,
    input  logic                   alu_lt,
    output logic                   busy
);
    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    localparam logic [3:0] MUL_OP   = 4'b1000;
    localparam logic [3:0] MUL_LAST = 4'(MUL_CYCLES - 1);

    state_t               state_q;
    logic                 ptr_q;
    logic                 owner_q;
    logic [3:0]           cnt_q;
    logic [3:0]           ctl_q;
    logic [REG_WIDTH-1:0] a_q;
    logic [REG_WIDTH-1:0] b_q;
    logic [REG_WIDTH-1:0] data_q;
    logic                 lt_q;

    logic [1:0]           grant;
    logic [3:0]           sel_ctl;
    logic [REG_WIDTH-1:0] sel_a;
    logic [REG_WIDTH-1:0] sel_b;

    // Contention is resolved by the pointer; a lone requester always wins.
    always_comb begin
        grant     = (req_valid == 2'b11) ? (ptr_q ? 2'b10 : 2'b01) : req_valid;
        req_ready = (state_q == IDLE) ? grant : 2'b00;
        sel_ctl   = req_ready[1] ? req_ctl[7:4] : req_ctl[3:0];
        sel_a     = req_ready[1] ? req_a[2*REG_WIDTH-1:REG_WIDTH] : req_a[REG_WIDTH-1:0];
        sel_b     = req_ready[1] ? req_b[2*REG_WIDTH-1:REG_WIDTH] : req_b[REG_WIDTH-1:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ptr_q   <= 1'b0;
            owner_q <= 1'b0;
            cnt_q   <= 4'd0;
            ctl_q   <= 4'd0;
            a_q     <= '0;
            b_q     <= '0;
            data_q  <= '0;
            lt_q    <= 1'b0;
        end else begin
            case (state_q)
                IDLE: if (|req_ready) begin
                    ctl_q   <= sel_ctl;
                    a_q     <= sel_a;
                    b_q     <= sel_b;
                    owner_q <= req_ready[1];
                    cnt_q   <= (sel_ctl == MUL_OP) ? MUL_LAST : 4'd0;
                    state_q <= EXEC;
                end
                EXEC: if (cnt_q == 4'd0) begin
                    data_q  <= alu_out;
                    lt_q    <= alu_lt;
                    state_q <= RESP;
                end else begin
                    cnt_q <= cnt_q - 4'd1;
                end
                RESP: if (rsp_ready[owner_q]) begin
                    ptr_q   <= ~owner_q;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign rsp_valid = (state_q == RESP) ? (owner_q ? 2'b10 : 2'b01) : 2'b00;
    assign rsp_data  = data_q;
    assign rsp_lt    = lt_q;
    assign alu_ctl   = ctl_q;
    assign alu_a     = a_q;
    assign alu_b     = b_q;
    assign busy      = (state_q != IDLE);
endmodule
